mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-side cache (read-only) and the data-side cache (read/write).
- Posts data-side writes into a small write buffer and drains it to memory when the port is free.
- Arbitrates read misses, and holds ownership of the port until the memory read completes.
- Sits between the two Cache instances and the main memory / bus model.

Parameters:
- WB_DEPTH, 4, write-buffer entries (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- CLK  in  1  clock
- Reset  in  1  asynchronous active-high reset
- i_ReadValid  in  1  I-cache read request; held until i_ReadReady
- i_ReadAddr  in  ADDR_W  I-cache read address; stable while valid
- i_ReadReady  out  1  one-cycle pulse, read data valid
- i_ReadData  out  DATA_W  read data to I-cache
- d_ReadValid  in  1  D-cache read request; held until d_ReadReady
- d_ReadAddr  in  ADDR_W  D-cache read address
- d_ReadReady  out  1  one-cycle pulse, read data valid
- d_ReadData  out  DATA_W  read data to D-cache
- d_WriteValid  in  1  single-cycle write post
- d_WriteAddr  in  ADDR_W  write address
- d_WriteData  in  DATA_W  write data
- wb_Full  out  1  write buffer full
- wb_Overflow  out  1  sticky: write dropped while full
- mem_ReadValid  out  1  memory read request
- mem_ReadAddr  out  ADDR_W  memory read address
- mem_ReadReady  in  1  memory read done, one-cycle pulse
- mem_ReadData  in  DATA_W  memory read data
- mem_WriteValid  out  1  memory write request
- mem_WriteAddr  out  ADDR_W  memory write address
- mem_WriteData  out  DATA_W  memory write data
- mem_WriteReady  in  1  memory write accepted

Behaviour:
- Clock and reset: one clock CLK; Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, write buffer empty, last_grant=D.
  - wb_Overflow=0.
  - All mem_* valid outputs and all *_ReadReady outputs 0.
  - Addresses and data outputs 0.
- Reset mid-transaction abandons the transaction. No ReadReady is issued; requesters re-request.
- States:
  - IDLE
  - RD_I: port owned by the I-side read
  - RD_D: port owned by the D-side read
  - WR: draining the write-buffer head
- IDLE decision, evaluated each cycle in priority order:
  - 1: buffer non-empty and (buffer full, or d_ReadValid with d_ReadAddr matching any valid buffer entry) -> WR
  - 2: read requests pending -> grant per arbitration (below) -> RD_I or RD_D
  - 3: buffer non-empty -> WR
  - 4: else stay IDLE
- Arbitration between pending reads: fixed D-over-I priority unless the optional feature is enabled.
- Registered outputs: mem_ReadValid/mem_ReadAddr and mem_WriteValid/Addr/Data are registered. They assert the cycle after the IDLE decision and are held stable until the matching memory ready.
- RD_x completion:
  - mem_ReadReady=1 -> x_ReadReady=1 in the same cycle, with x_ReadData=mem_ReadData passed through combinationally.
  - mem_ReadValid drops next cycle; state -> IDLE.
  - Minimum read latency: request at cycle N, mem_ReadValid at N+1, earliest ReadReady at N+1.
- Read data outside a completion: non-granted ReadReady=0 and ReadData=0.
- WR completion: mem_WriteReady=1 -> pop head; state -> IDLE next cycle.
- Write buffer:
  - d_WriteValid is accepted in any state when not full.
  - When full, a write is accepted only if a pop occurs in the same cycle. Push and pop in the same cycle leave the count unchanged.
  - Otherwise the write is dropped and wb_Overflow sets (sticky until Reset).
- wb_Full is combinational from count==WB_DEPTH.
- Pointers wrap modulo WB_DEPTH; the count is ADDR-independent, width clog2(WB_DEPTH)+1.
- Address-match compare: full-width compare against valid entries only.
- Simultaneous mem_ReadReady and a new request from the same side: the new request is considered only in IDLE.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin read arbitration. When both sides request, grant the side that is not last_grant; last_grant updates on every read grant.
- MEM_ARB_RR_EN undefined: fixed priority, D before I; last_grant unused (may be optimised out).

Test Plan:
- Single I read:
  - Stimulus: i_ReadValid, addr 0x0000_0040; memory returns 0xDEAD_BEEF after 3 cycles.
  - Required: mem_ReadAddr=0x40 held; i_ReadReady pulses once with 0xDEAD_BEEF; no d_ReadReady.
- Simultaneous I and D reads, repeated twice:
  - Without macro: D granted both times.
  - With MEM_ARB_RR_EN: grant order D, I, D, I.
- Write posting and drain:
  - Stimulus: three writes (0x100→0x11, 0x104→0x22, 0x108→0x33) with no reads.
  - Required: memory sees them in order; wb_Full never set; buffer empty afterwards.
- Read-after-write hazard:
  - Stimulus: post write 0x200→0x55, then immediately d_ReadValid for 0x200.
  - Required: the WR to 0x200 completes before mem_ReadValid for 0x200 asserts.
- Overflow:
  - Stimulus: hold mem_WriteReady=0; post 5 writes with WB_DEPTH=4.
  - Required: wb_Full=1 after the 4th write; the 5th write is dropped; wb_Overflow=1 and stays 1.
- Reset mid-read:
  - Stimulus: assert Reset during RD_D, before mem_ReadReady.
  - Required: mem_ReadValid=0 immediately; d_ReadReady never pulses; buffer count=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter for the I-cache and D-cache, with a posted write buffer.
// Define MEM_ARB_RR_EN for round-robin read arbitration (default: D-side has fixed priority).
module mem_arbiter #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              i_ReadValid,
  input  logic [ADDR_W-1:0] i_ReadAddr,
  output logic              i_ReadReady,
  output logic [DATA_W-1:0] i_ReadData,
  input  logic              d_ReadValid,
  input  logic [ADDR_W-1:0] d_ReadAddr,
  output logic              d_ReadReady,
  output logic [DATA_W-1:0] d_ReadData,
  input  logic              d_WriteValid,
  input  logic [ADDR_W-1:0] d_WriteAddr,
  input  logic [DATA_W-1:0] d_WriteData,
  output logic              wb_Full,
  output logic              wb_Overflow,
  output logic              mem_ReadValid,
  output logic [ADDR_W-1:0] mem_ReadAddr,
  input  logic              mem_ReadReady,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              mem_WriteValid,
  output logic [ADDR_W-1:0] mem_WriteAddr,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic              mem_WriteReady
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wb_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]   wb_data_q [WB_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;
  logic                mem_rd_valid_q, mem_rd_valid_d;
  logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic                mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_W-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;

  logic                wb_full_s, wb_empty_s, push_s, pop_s, drop_s;
  logic                hazard_s, grant_d_s;
  logic [PTR_W-1:0]    offset_s;

`ifdef MEM_ARB_RR_EN
  logic                last_grant_q, last_grant_d;  // 1 = D side
`endif

  assign wb_full_s  = (count_q == CNT_W'(WB_DEPTH));
  assign wb_empty_s = (count_q == {CNT_W{1'b0}});
  assign pop_s      = (state_q == WR) && mem_WriteReady;
  // A write into a full buffer survives only if the head drains in the same cycle.
  assign push_s     = d_WriteValid && (!wb_full_s || pop_s);
  assign drop_s     = d_WriteValid && wb_full_s && !pop_s;

`ifdef MEM_ARB_RR_EN
  assign grant_d_s  = d_ReadValid && (!i_ReadValid || !last_grant_q);
`else
  assign grant_d_s  = d_ReadValid;
`endif

  // Entry k is live when its distance from the head is below the count.
  always_comb begin
    hazard_s = 1'b0;
    offset_s = {PTR_W{1'b0}};
    for (int k = 0; k < WB_DEPTH; k++) begin
      offset_s = PTR_W'(k) - rd_ptr_q;
      if (({1'b0, offset_s} < count_q) && (wb_addr_q[k] == d_ReadAddr)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (!wb_empty_s && (wb_full_s || (d_ReadValid && hazard_s))) begin
          state_d        = WR;
          mem_wr_valid_d = 1'b1;
          mem_wr_addr_d  = wb_addr_q[rd_ptr_q];
          mem_wr_data_d  = wb_data_q[rd_ptr_q];
        end else if (i_ReadValid || d_ReadValid) begin
          mem_rd_valid_d = 1'b1;
          if (grant_d_s) begin
            state_d       = RD_D;
            mem_rd_addr_d = d_ReadAddr;
          end else begin
            state_d       = RD_I;
            mem_rd_addr_d = i_ReadAddr;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_d = grant_d_s;
`endif
        end else if (!wb_empty_s) begin
          state_d        = WR;
          mem_wr_valid_d = 1'b1;
          mem_wr_addr_d  = wb_addr_q[rd_ptr_q];
          mem_wr_data_d  = wb_data_q[rd_ptr_q];
        end else begin
          state_d = IDLE;
        end
      end
      RD_I, RD_D: begin
        if (mem_ReadReady) begin
          state_d        = IDLE;
          mem_rd_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      WR: begin
        if (mem_WriteReady) begin
          state_d        = IDLE;
          mem_wr_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d        = IDLE;
        mem_rd_valid_d = 1'b0;
        mem_wr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= {ADDR_W{1'b0}};
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= {ADDR_W{1'b0}};
      mem_wr_data_q  <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        wb_addr_q[k] <= {ADDR_W{1'b0}};
        wb_data_q[k] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        wb_addr_q[wr_ptr_q] <= d_WriteAddr;
        wb_data_q[wr_ptr_q] <= d_WriteData;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= overflow_q | drop_s;
    end
  end

  assign i_ReadReady    = (state_q == RD_I) && mem_ReadReady;
  assign d_ReadReady    = (state_q == RD_D) && mem_ReadReady;
  assign i_ReadData     = i_ReadReady ? mem_ReadData : {DATA_W{1'b0}};
  assign d_ReadData     = d_ReadReady ? mem_ReadData : {DATA_W{1'b0}};
  assign wb_Full        = wb_full_s;
  assign wb_Overflow    = overflow_q;
  assign mem_ReadValid  = mem_rd_valid_q;
  assign mem_ReadAddr   = mem_rd_addr_q;
  assign mem_WriteValid = mem_wr_valid_q;
  assign mem_WriteAddr  = mem_wr_addr_q;
  assign mem_WriteData  = mem_wr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, arbitration, write posting, hazard, overflow, reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        i_ReadValid, i_ReadReady;
  logic [31:0] i_ReadAddr, i_ReadData;
  logic        d_ReadValid, d_ReadReady;
  logic [31:0] d_ReadAddr, d_ReadData;
  logic        d_WriteValid;
  logic [31:0] d_WriteAddr, d_WriteData;
  logic        wb_Full, wb_Overflow;
  logic        mem_ReadValid, mem_ReadReady;
  logic [31:0] mem_ReadAddr, mem_ReadData;
  logic        mem_WriteValid, mem_WriteReady;
  logic [31:0] mem_WriteAddr, mem_WriteData;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WB_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .i_ReadValid(i_ReadValid), .i_ReadAddr(i_ReadAddr),
    .i_ReadReady(i_ReadReady), .i_ReadData(i_ReadData),
    .d_ReadValid(d_ReadValid), .d_ReadAddr(d_ReadAddr),
    .d_ReadReady(d_ReadReady), .d_ReadData(d_ReadData),
    .d_WriteValid(d_WriteValid), .d_WriteAddr(d_WriteAddr), .d_WriteData(d_WriteData),
    .wb_Full(wb_Full), .wb_Overflow(wb_Overflow),
    .mem_ReadValid(mem_ReadValid), .mem_ReadAddr(mem_ReadAddr),
    .mem_ReadReady(mem_ReadReady), .mem_ReadData(mem_ReadData),
    .mem_WriteValid(mem_WriteValid), .mem_WriteAddr(mem_WriteAddr),
    .mem_WriteData(mem_WriteData), .mem_WriteReady(mem_WriteReady)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    i_ReadValid = 1'b0; i_ReadAddr = 32'h0;
    d_ReadValid = 1'b0; d_ReadAddr = 32'h0;
    d_WriteValid = 1'b0; d_WriteAddr = 32'h0; d_WriteData = 32'h0;
    mem_ReadReady = 1'b0; mem_ReadData = 32'h0; mem_WriteReady = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  // Waits (bounded) for a memory read, answers it for one cycle, reports who got it.
  task automatic serve_read(input logic [31:0] data, output logic [31:0] addr,
                            output logic got_i, output logic got_d,
                            output logic [31:0] rdata, output logic ok);
    ok = 1'b0; addr = 32'h0; got_i = 1'b0; got_d = 1'b0; rdata = 32'h0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge CLK);
      if (mem_ReadValid) ok = 1'b1;
    end
    if (ok) begin
      addr = mem_ReadAddr;
      mem_ReadReady = 1'b1; mem_ReadData = data;
      #1;
      got_i = i_ReadReady; got_d = d_ReadReady;
      rdata = got_i ? i_ReadData : d_ReadData;
      @(negedge CLK);
      mem_ReadReady = 1'b0; mem_ReadData = 32'h0;
    end
  endtask

  task automatic serve_write(output logic [31:0] addr, output logic [31:0] data, output logic ok);
    ok = 1'b0; addr = 32'h0; data = 32'h0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge CLK);
      if (mem_WriteValid) ok = 1'b1;
    end
    if (ok) begin
      addr = mem_WriteAddr; data = mem_WriteData;
      mem_WriteReady = 1'b1;
      @(negedge CLK);
      mem_WriteReady = 1'b0;
    end
  endtask

  task automatic test_reset;
    i_ReadValid = 1'b0; d_ReadValid = 1'b0; d_WriteValid = 1'b0;
    mem_ReadReady = 1'b0; mem_WriteReady = 1'b0;
    Reset = 1'b1;
    #12;
    n_checks++;
    if ({mem_ReadValid, mem_WriteValid, i_ReadReady, d_ReadReady, wb_Full, wb_Overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {mem_ReadValid, mem_WriteValid, i_ReadReady, d_ReadReady, wb_Full, wb_Overflow});
    end
    n_checks++;
    if ({mem_ReadAddr, mem_WriteAddr, mem_WriteData} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h %h %h want 0", mem_ReadAddr, mem_WriteAddr, mem_WriteData);
    end
    do_reset();
  endtask

  task automatic test_single_i_read;
    do_reset();
    i_ReadValid = 1'b1; i_ReadAddr = 32'h0000_0040;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_checks++;
      if (mem_ReadValid !== 1'b1 || mem_ReadAddr !== 32'h40) begin
        n_fail++;
        $display("FAIL i_read_req cycle %0d: got valid=%b addr=%h want 1 00000040", c, mem_ReadValid, mem_ReadAddr);
      end
    end
    @(negedge CLK);
    mem_ReadReady = 1'b1; mem_ReadData = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (i_ReadReady !== 1'b1 || i_ReadData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL i_read_data: got rdy=%b data=%h want 1 deadbeef", i_ReadReady, i_ReadData);
    end
    n_checks++;
    if (d_ReadReady !== 1'b0 || d_ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL i_read_no_d: got rdy=%b data=%h want 0 0", d_ReadReady, d_ReadData);
    end
    @(negedge CLK);
    mem_ReadReady = 1'b0; mem_ReadData = 32'h0; i_ReadValid = 1'b0;
    #1;
    n_checks++;
    if (mem_ReadValid !== 1'b0 || i_ReadReady !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_done: got valid=%b rdy=%b want 0 0", mem_ReadValid, i_ReadReady);
    end
  endtask

  // Runs straight after the I read, so a round-robin arbiter starts with last grant = I.
  task automatic test_simultaneous_reads;
    logic [31:0] addr, rdata;
    logic        got_i, got_d, ok, exp_d;
    int          rounds;
`ifdef MEM_ARB_RR_EN
    rounds = 4;
`else
    rounds = 2;
`endif
    i_ReadValid = 1'b1; i_ReadAddr = 32'h80;
    d_ReadValid = 1'b1; d_ReadAddr = 32'h84;
    for (int r = 0; r < rounds; r++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      serve_read(32'h1000 + r, addr, got_i, got_d, rdata, ok);
      n_checks++;
      if (ok !== 1'b1 || got_d !== exp_d || got_i !== !exp_d || addr !== (exp_d ? 32'h84 : 32'h80)
          || rdata !== 32'h1000 + r) begin
        n_fail++;
        $display("FAIL arb_round %0d: got ok=%b d=%b i=%b addr=%h data=%h want d=%b", r, ok, got_d, got_i,
                 addr, rdata, exp_d);
      end
    end
`ifndef MEM_ARB_RR_EN
    d_ReadValid = 1'b0;
    serve_read(32'h2000, addr, got_i, got_d, rdata, ok);
    n_checks++;
    if (ok !== 1'b1 || got_i !== 1'b1 || addr !== 32'h80 || rdata !== 32'h2000) begin
      n_fail++;
      $display("FAIL arb_i_after_d: got ok=%b i=%b addr=%h data=%h want 1 1 00000080 00002000", ok, got_i, addr, rdata);
    end
`endif
    i_ReadValid = 1'b0; d_ReadValid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write_drain;
    logic [31:0] exp_a [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp_w [3] = '{32'h11, 32'h22, 32'h33};
    logic [31:0] addr, data;
    logic        ok, full_seen;
    int          extra;
    do_reset();
    full_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d_WriteValid = 1'b1; d_WriteAddr = exp_a[k]; d_WriteData = exp_w[k];
      @(negedge CLK);
      full_seen = full_seen | wb_Full;
    end
    d_WriteValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      serve_write(addr, data, ok);
      full_seen = full_seen | wb_Full;
      n_checks++;
      if (ok !== 1'b1 || addr !== exp_a[k] || data !== exp_w[k]) begin
        n_fail++;
        $display("FAIL drain_%0d: got ok=%b addr=%h data=%h want %h %h", k, ok, addr, data, exp_a[k], exp_w[k]);
      end
    end
    extra = 0;
    repeat (8) begin
      @(negedge CLK);
      if (mem_WriteValid) extra++;
    end
    n_checks++;
    if (full_seen !== 1'b0 || extra != 0) begin
      n_fail++;
      $display("FAIL drain_empty: got full_seen=%b extra_cycles=%0d want 0 0", full_seen, extra);
    end
  endtask

  task automatic test_raw_hazard;
    logic [31:0] addr, rdata;
    logic        got_i, got_d, ok, wr_first, seen;
    do_reset();
    d_WriteValid = 1'b1; d_WriteAddr = 32'h200; d_WriteData = 32'h55;
    @(negedge CLK);
    d_WriteValid = 1'b0;
    d_ReadValid = 1'b1; d_ReadAddr = 32'h200;
    seen = 1'b0; wr_first = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (mem_WriteValid || mem_ReadValid) begin
        seen = 1'b1;
        wr_first = mem_WriteValid && !mem_ReadValid;
      end
    end
    n_checks++;
    if (wr_first !== 1'b1 || mem_WriteAddr !== 32'h200 || mem_WriteData !== 32'h55) begin
      n_fail++;
      $display("FAIL raw_write_first: got wr_first=%b addr=%h data=%h want 1 00000200 00000055",
               wr_first, mem_WriteAddr, mem_WriteData);
    end
    mem_WriteReady = 1'b1;
    @(negedge CLK);
    mem_WriteReady = 1'b0;
    serve_read(32'h77, addr, got_i, got_d, rdata, ok);
    n_checks++;
    if (ok !== 1'b1 || got_d !== 1'b1 || addr !== 32'h200 || rdata !== 32'h77) begin
      n_fail++;
      $display("FAIL raw_read_after: got ok=%b d=%b addr=%h data=%h want 1 1 00000200 00000077", ok, got_d, addr, rdata);
    end
    d_ReadValid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_overflow;
    logic [31:0] exp_a [4] = '{32'h304, 32'h308, 32'h30C, 32'h400};
    logic [31:0] exp_w [4] = '{32'h31, 32'h32, 32'h33, 32'h44};
    logic [31:0] addr, data;
    logic        ok;
    int          extra;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      d_WriteValid = 1'b1; d_WriteAddr = 32'h300 + 4 * k; d_WriteData = 32'h30 + k;
      @(negedge CLK);
      n_checks++;
      if (wb_Full !== (k >= 3) || wb_Overflow !== (k == 4)) begin
        n_fail++;
        $display("FAIL ovf_post_%0d: got full=%b ovf=%b want %b %b", k, wb_Full, wb_Overflow, k >= 3, k == 4);
      end
    end
    d_WriteValid = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (wb_Overflow !== 1'b1 || wb_Full !== 1'b1 || mem_WriteValid !== 1'b1 || mem_WriteAddr !== 32'h300) begin
      n_fail++;
      $display("FAIL ovf_hold: got ovf=%b full=%b wv=%b wa=%h want 1 1 1 00000300",
               wb_Overflow, wb_Full, mem_WriteValid, mem_WriteAddr);
    end
    // Push into a full buffer while the head drains: must be accepted.
    mem_WriteReady = 1'b1;
    d_WriteValid = 1'b1; d_WriteAddr = 32'h400; d_WriteData = 32'h44;
    @(negedge CLK);
    mem_WriteReady = 1'b0; d_WriteValid = 1'b0;
    n_checks++;
    if (wb_Full !== 1'b1) begin
      n_fail++;
      $display("FAIL push_pop_full: got full=%b want 1", wb_Full);
    end
    for (int k = 0; k < 4; k++) begin
      serve_write(addr, data, ok);
      n_checks++;
      if (ok !== 1'b1 || addr !== exp_a[k] || data !== exp_w[k]) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got ok=%b addr=%h data=%h want %h %h", k, ok, addr, data, exp_a[k], exp_w[k]);
      end
    end
    extra = 0;
    repeat (8) begin
      @(negedge CLK);
      if (mem_WriteValid) extra++;
    end
    n_checks++;
    if (extra != 0 || wb_Full !== 1'b0 || wb_Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: got extra=%0d full=%b ovf=%b want 0 0 1", extra, wb_Full, wb_Overflow);
    end
  endtask

  task automatic test_reset_mid_read;
    int bad;
    do_reset();
    d_WriteValid = 1'b1; d_WriteAddr = 32'h600; d_WriteData = 32'h66;
    @(negedge CLK);
    d_WriteValid = 1'b0;
    d_ReadValid = 1'b1; d_ReadAddr = 32'h500;
    @(negedge CLK);
    n_checks++;
    if (mem_ReadValid !== 1'b1 || mem_ReadAddr !== 32'h500 || mem_WriteValid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_before_drain: got rv=%b ra=%h wv=%b want 1 00000500 0", mem_ReadValid, mem_ReadAddr, mem_WriteValid);
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (mem_ReadValid !== 1'b0 || d_ReadReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got rv=%b drdy=%b want 0 0", mem_ReadValid, d_ReadReady);
    end
    d_ReadValid = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (d_ReadReady || mem_ReadValid || mem_WriteValid || wb_Full) bad++;
    end
    n_checks++;
    if (bad != 0 || wb_Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: got active_cycles=%0d ovf=%b want 0 0", bad, wb_Overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_simultaneous_reads();
    test_write_drain();
    test_raw_hazard();
    test_overflow();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
